// File: rtl/out_state.sv
`default_nettype none
// ============================================================================
// Module      : out_state
// Description : Toll-gate PASS/FAIL indicator. It drives a 7-segment pattern and
//               an optional buzzer tone, which is built when OUT_STATE_SOUND_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module out_state #(
  parameter int HOLD_CYCLES = 16,
  parameter int TONE_DIV    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] en,
  input  logic [3:0] hipass,
  output logic [6:0] out,
  output logic       sound_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PASS = 2'd1;
  localparam logic [1:0] S_FAIL = 2'd2;

  localparam logic [7:0] c_HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255 || TONE_DIV < 1 || TONE_DIV > 255) begin : g_param_check
    $error("out_state: parameter out of legal range");
  end

  logic [1:0] state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] prev_q;
  logic       w_is_pass, w_is_fail, w_event;

  assign w_is_pass = hipass[3] && (hipass[2:0] != 3'b111);
  assign w_is_fail = (hipass == 4'b1111);
  // A code that is held steady must not retrigger, so only a change counts.
  assign w_event   = (en != 2'b00) && (w_is_pass || w_is_fail) && (hipass != prev_q);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (en == 2'b00) begin
      state_d = S_IDLE;
      timer_d = '0;
    end else if (w_event) begin
      state_d = w_is_fail ? S_FAIL : S_PASS;
      timer_d = c_HOLD_LOAD;
    end else if (state_q != S_IDLE) begin
      if (timer_q == 8'd0) state_d = S_IDLE;
      else                 timer_d = timer_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      prev_q  <= hipass;
    end
  end

  always_comb begin
    out = 7'b0000000;
    if (en[0]) begin
      case (state_q)
        S_PASS:  out = 7'b1110011;
        S_FAIL:  out = 7'b1110001;
        default: out = 7'b1000000;
      endcase
    end
  end

`ifdef OUT_STATE_SOUND_EN
  localparam logic [7:0] c_TONE_LAST = 8'(TONE_DIV - 1);

  logic [7:0] tone_cnt_q;
  logic       tone_q;

  always_ff @(posedge clk) begin
    if (!rst || state_q == S_IDLE) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else if (tone_cnt_q == c_TONE_LAST) begin
      tone_cnt_q <= '0;
      tone_q     <= ~tone_q;
    end else begin
      tone_cnt_q <= tone_cnt_q + 8'd1;
    end
  end

  // FAIL gates the tone with timer bit 2 for an intermittent beep.
  always_comb begin
    sound_out = 1'b0;
    if (en[1]) begin
      case (state_q)
        S_PASS:  sound_out = tone_q;
        S_FAIL:  sound_out = tone_q & ~timer_q[2];
        default: sound_out = 1'b0;
      endcase
    end
  end
`else
  assign sound_out = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_out_state.sv
`default_nettype none
// Testbench for out_state: directed scenarios followed by random traffic,
// with every cycle compared against a cycle-count reference model.
module tb_out_state;

  localparam int HOLD = 16;
  localparam int TDIV = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] en = 2'b00;
  logic [3:0] hipass = 4'b0000;
  logic [6:0] out;
  logic       sound_out;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: mode 0=idle 1=pass 2=fail, left = cycles of
  // indication remaining, ticks = active cycles since the tone last restarted.
  int         m_mode  = 0;
  int         m_left  = 0;
  int         m_ticks = 0;
  logic [3:0] m_prev  = 4'b0000;

  out_state #(.HOLD_CYCLES(HOLD), .TONE_DIV(TDIV)) dut (
    .clk(clk), .rst(rst), .en(en), .hipass(hipass),
    .out(out), .sound_out(sound_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [1:0] e, input logic [3:0] h);
    int cls;
    if (!r) begin
      m_mode = 0; m_left = 0; m_ticks = 0; m_prev = 4'b0000;
    end else begin
      m_ticks = (m_mode == 0) ? 0 : m_ticks + 1;
      cls = (h == 4'b1111) ? 2 : (h[3] ? 1 : 0);
      if (e == 2'b00) begin
        m_mode = 0; m_left = 0;
      end else if (cls != 0 && h != m_prev) begin
        m_mode = cls; m_left = HOLD;
      end else if (m_mode != 0) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 0;
      end
      m_prev = h;
    end
  endtask

  function automatic logic [6:0] exp_out();
    if (!en[0]) return 7'b0000000;
    case (m_mode)
      1:       return 7'b1110011;
      2:       return 7'b1110001;
      default: return 7'b1000000;
    endcase
  endfunction

  function automatic logic exp_sound();
`ifdef OUT_STATE_SOUND_EN
    logic tone;
    logic tbit;
    tone = ((m_ticks / TDIV) % 2) == 1;
    tbit = (((m_left - 1) / 4) % 2) == 1;
    if (!en[1] || m_mode == 0) return 1'b0;
    if (m_mode == 1) return tone;
    return tone & ~tbit;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input logic r, input logic [1:0] e, input logic [3:0] h);
    rst = r; en = e; hipass = h;
    @(posedge clk);
    model_edge(r, e, h);
    #1;
    chk("out", {1'b0, out}, {1'b0, exp_out()});
    chk("sound_out", {7'b0, sound_out}, {7'b0, exp_sound()});
  endtask

  task automatic run(input int n, input logic [1:0] e, input logic [3:0] h);
    for (int i = 0; i < n; i++) step(1'b1, e, h);
  endtask

  initial begin
    // Reset with everything disabled, then enable the display.
    step(1'b0, 2'b00, 4'b0000);
    step(1'b0, 2'b00, 4'b0000);
    chk("rst_out_dark", {1'b0, out}, 8'h00);
    chk("rst_sound", {7'b0, sound_out}, 8'h00);
    step(1'b1, 2'b00, 4'b0000);
    step(1'b1, 2'b11, 4'b0000);
    chk("idle_dash", {1'b0, out}, {1'b0, 7'b1000000});

    // PASS: immediate pattern, then back to idle after the hold time.
    step(1'b1, 2'b11, 4'b1110);
    chk("pass_now", {1'b0, out}, {1'b0, 7'b1110011});
    run(HOLD - 1, 2'b11, 4'b1110);
    chk("pass_last", {1'b0, out}, {1'b0, 7'b1110011});
    step(1'b1, 2'b11, 4'b1110);
    chk("pass_done", {1'b0, out}, {1'b0, 7'b1000000});

    // FAIL after a no-event code.
    step(1'b1, 2'b11, 4'b0000);
    step(1'b1, 2'b11, 4'b1111);
    chk("fail_now", {1'b0, out}, {1'b0, 7'b1110001});
    run(HOLD + 2, 2'b11, 4'b1111);
    chk("fail_done", {1'b0, out}, {1'b0, 7'b1000000});

    // Held code never retriggers; a new FAIL code overrides PASS.
    step(1'b1, 2'b11, 4'b0000);
    run(40, 2'b11, 4'b1110);
    chk("hold_no_retrig", {1'b0, out}, {1'b0, 7'b1000000});
    step(1'b1, 2'b11, 4'b0000);
    run(5, 2'b11, 4'b1110);
    step(1'b1, 2'b11, 4'b1111);
    chk("fail_override", {1'b0, out}, {1'b0, 7'b1110001});
    run(HOLD - 1, 2'b11, 4'b1111);
    chk("fail_reloaded", {1'b0, out}, {1'b0, 7'b1110001});
    run(2, 2'b11, 4'b1111);

    // Partial enables and disable mid-FAIL.
    step(1'b1, 2'b01, 4'b0000);
    step(1'b1, 2'b01, 4'b1010);
    chk("en1_pass", {1'b0, out}, {1'b0, 7'b1110011});
    chk("en1_quiet", {7'b0, sound_out}, 8'h00);
    run(HOLD, 2'b10, 4'b1010);
    step(1'b1, 2'b10, 4'b0001);
    run(6, 2'b10, 4'b1001);
    chk("en2_dark", {1'b0, out}, 8'h00);
    step(1'b1, 2'b11, 4'b1111);
    run(4, 2'b11, 4'b1111);
    step(1'b1, 2'b00, 4'b1111);
    step(1'b1, 2'b11, 4'b1111);
    chk("en0_abort", {1'b0, out}, {1'b0, 7'b1000000});

    // Reset mid-PASS wins over a simultaneous event.
    step(1'b1, 2'b11, 4'b1000);
    run(3, 2'b11, 4'b1000);
    step(1'b0, 2'b11, 4'b1100);
    chk("rst_abort", {1'b0, out}, {1'b0, 7'b1000000});
    chk("rst_abort_snd", {7'b0, sound_out}, 8'h00);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] h;
      logic [1:0] e;
      logic       r;
      case ($urandom_range(0, 9))
        0, 1, 2: h = hipass;
        3:       h = 4'b0000;
        4:       h = 4'b1111;
        default: h = 4'($urandom);
      endcase
      e = ($urandom_range(0, 9) < 7) ? 2'b11 : 2'($urandom);
      r = ($urandom_range(0, 99) != 0);
      step(r, e, h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/out_state.md
OUT_STATE -- requirements
Module: out_state

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: clock cycles a PASS/FAIL indication is held (legal 2..255).
REQ-002 Parameter TONE_DIV, default 2: clock cycles per half-period of the buzzer square wave (legal 1..255).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 en  input  2  en[0] display enable, en[1] sound enable.
REQ-006 hipass  input  4  toll-reader code: hipass[3] card detected, hipass[2:0] status (3'b111 = rejected).
REQ-007 out  output  7  7-segment pattern, active-high, bit order {g,f,e,d,c,b,a}.
REQ-008 sound_out  output  1  buzzer drive.

Function
REQ-009 The block SHALL have three states: IDLE, PASS, FAIL, plus an 8-bit hold timer, a 4-bit previous-code register and a tone counter.
REQ-010 Code classification: hipass[3]=1 and hipass[2:0]!=3'b111 is PASS; hipass=4'b1111 is FAIL; any code with hipass[3]=0 is no-event.
REQ-011 An event SHALL occur on an edge where en!=2'b00, hipass is PASS or FAIL class, and hipass differs from the previous-code register; a held code never retriggers.
REQ-012 The previous-code register SHALL load hipass on every non-reset edge regardless of en.
REQ-013 On an event, state SHALL load the event class and the timer SHALL load HOLD_CYCLES-1 on the same edge, including when already in PASS/FAIL (retrigger overrides the current indication).
REQ-014 In PASS/FAIL without an event, the timer SHALL decrement each edge; on the edge where it is 0, state SHALL return to IDLE.
REQ-015 When en==2'b00, state SHALL be forced to IDLE and the timer cleared on each edge.
REQ-016 out SHALL be decoded combinationally from state: IDLE 7'b1000000 ("-"), PASS 7'b1110011 ("P"), FAIL 7'b1110001 ("F"); out SHALL be 7'b0000000 when en[0]=0.
REQ-017 Latency: code applied before edge N produces the new out pattern immediately after edge N.
REQ-018 Tone counter SHALL count 0..TONE_DIV-1 and toggle a tone register at wrap while state!=IDLE; in IDLE both are held at 0.
REQ-019 sound_out SHALL equal tone register in PASS, tone register AND NOT timer[2] in FAIL (intermittent), and 0 in IDLE or when en[1]=0.

Reset
REQ-020 With rst=0 at a rising edge: state IDLE, timer 0, previous-code 4'b0000, tone counter 0, tone register 0.
REQ-021 During/after reset out SHALL be 7'b1000000 if en[0]=1 else 7'b0000000, and sound_out SHALL be 0.
REQ-022 Reset SHALL take priority over an event on the same edge; reset mid-indication SHALL abort it immediately.

Configuration
REQ-023 Macro OUT_STATE_SOUND_EN defined: tone counter, tone register and sound_out behave per REQ-018/019.
REQ-024 Macro OUT_STATE_SOUND_EN undefined: tone logic is not built, sound_out is constant 0, en[1] still counts toward REQ-011/015, display unaffected.

Verification
REQ-025 rst=0 two cycles, en=0, hipass=0, then rst=1 -> out=7'b0000000, sound_out=0; en=3 -> out=7'b1000000.
REQ-026 en=3, hipass 0000->1110 -> next edge out=7'b1110011, sound_out toggles every 2 cycles; after 16 cycles out=7'b1000000, sound_out=0.
REQ-027 en=3, hipass 1110->0000->1111 -> out=7'b1110001, sound_out toggles only while timer[2]=0; returns to IDLE 16 cycles later.
REQ-028 Hold hipass=1110 for 40 cycles with en=3 -> single 16-cycle PASS, no retrigger; then 1111 during PASS -> immediate FAIL with timer reloaded.
REQ-029 en=1 with PASS event -> out=7'b1110011, sound_out=0; en=2 -> out=7'b0000000, sound_out toggling; en=0 mid-FAIL -> IDLE next edge.
REQ-030 rst=0 asserted mid-PASS -> next edge state IDLE, sound_out=0; build without OUT_STATE_SOUND_EN -> sound_out=0 in all above scenarios.
